// File: rtl/key_scan_encoder_pkg.sv
// Shared types and sizes for the key scan encoder: FSM state encoding and key vector widths.
package key_pkg;

    localparam int KEY_NUM   = 8;
    localparam int KEY_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

endpackage

// File: rtl/key_scan_encoder_if.sv
// Key scan encoder bus: raw active-low buttons in, encoded key index, strobe and hold flag out.
interface key_scan_encoder_if;

    logic [key_pkg::KEY_NUM-1:0]   key_n;
    logic [key_pkg::KEY_IDX_W-1:0] keyin;
    logic                          code_valid;
    logic                          key_held;

    // master drives the buttons and observes the code; slave is the encoder itself
    modport master (output key_n, input keyin, input code_valid, input key_held);
    modport slave  (input key_n, output keyin, output code_valid, output key_held);

endinterface

// File: rtl/key_scan_encoder_prio_enc.sv
// Combinational lowest-set-bit priority encoder; the output for an all-zero input is don't-care.
module key_prio_enc
    import key_pkg::*;
(
    input  logic [KEY_NUM-1:0]   vec,
    output logic [KEY_IDX_W-1:0] idx
);

    // NOTE: idx gets a value before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[KEY_IDX_W-1:0];
        end
    end

endmodule

// File: rtl/key_scan_encoder.sv
// Debounced 8-button scanner producing a 3-bit key code for the LED decoder.
// Optional auto-repeat of the strobe while a key is held: define KEY_AUTO_REPEAT_EN.
module key_scan_encoder
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 20,
    parameter int REPEAT_CYC   = 25_000_000
) (
    input logic               clk,
    input logic               rst_n,
    key_scan_encoder_if.slave bus
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [KEY_NUM-1:0]   sync1, sync2, snap, act;
    logic [CNT_W-1:0]     cnt;
    logic [KEY_IDX_W-1:0] enc_idx;
    logic [KEY_IDX_W-1:0] keyin_q;
    logic                 code_valid_q, key_held_q;
    logic                 db_done, accept, release_done, repeat_fire;
    state_t               state, state_nx;

    assign act     = ~sync2;
    assign db_done = (act == snap) && (cnt == DB_MAX);

    key_prio_enc u_prio_enc (
        .vec (act),
        .idx (enc_idx)
    );

    // NOTE: state-holding logic uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            snap  <= '0;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            state <= state_nx;
            if (act != snap) begin
                snap <= act;
                cnt  <= '0;
            end else if (cnt != DB_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        accept       = 1'b0;
        release_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (act != '0) state_nx = PRESS_DB;
            end
            PRESS_DB: begin
                if (act == '0) begin
                    state_nx = IDLE;
                end else if (db_done) begin
                    state_nx = PRESSED;
                    accept   = 1'b1;
                end
            end
            PRESSED: begin
                if (act == '0) state_nx = REL_DB;
            end
            REL_DB: begin
                // any key reappearing is treated as release bounce, not a new press
                if (act != '0) begin
                    state_nx = PRESSED;
                end else if (db_done) begin
                    state_nx     = IDLE;
                    release_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] rep_cnt;

    assign repeat_fire = (state == PRESSED) && (rep_cnt == REP_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (state_nx == PRESSED && state != PRESSED) begin
            rep_cnt <= '0;
        end else if (state == PRESSED) begin
            rep_cnt <= repeat_fire ? '0 : rep_cnt + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyin_q      <= '0;
            code_valid_q <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            code_valid_q <= accept | repeat_fire;
            if (accept) begin
                keyin_q    <= enc_idx;
                key_held_q <= 1'b1;
            end else if (release_done) begin
                key_held_q <= 1'b0;
            end
        end
    end

    assign bus.keyin      = keyin_q;
    assign bus.code_valid = code_valid_q;
    assign bus.key_held   = key_held_q;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder with short debounce/repeat periods; honours KEY_AUTO_REPEAT_EN.
module tb_key_scan_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    key_scan_encoder_if kif ();

    key_scan_encoder #(
        .DEBOUNCE_CYC (4),
        .CNT_W        (4),
        .REPEAT_CYC   (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    int errors = 0;
    int checks = 0;
    int tick_n;
    int pulses;
    int pulse_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        tick_n = 0;
        pulses = 0;
        pulse_q.delete();
    endtask

    // advance n cycles, sampling 1 time unit after each rising edge
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tick_n++;
            if (kif.code_valid === 1'b1) begin
                pulses++;
                pulse_q.push_back(tick_n);
            end
        end
    endtask

    function automatic int pulse_at(input int k);
        return (pulse_q.size() > k) ? pulse_q[k] : -1;
    endfunction

    initial begin
        // reset behaviour
        rst_n     = 1'b0;
        kif.key_n = 8'hFF;
        #2;
        check("rst_keyin", kif.keyin, 0);
        check("rst_code_valid", kif.code_valid, 0);
        check("rst_key_held", kif.key_held, 0);
        clear_mon();
        run(3);
        rst_n = 1'b1;
        clear_mon();
        run(5);
        check("idle_pulses", pulses, 0);
        check("idle_keyin", kif.keyin, 0);
        check("idle_held", kif.key_held, 0);

        // clean press of key 3: strobe 7 cycles after the pin change
        clear_mon();
        kif.key_n = 8'hF7;
        run(6);
        check("k3_no_early_strobe", pulses, 0);
        run(1);
        check("k3_code_valid", kif.code_valid, 1);
        check("k3_keyin", kif.keyin, 3);
        check("k3_held", kif.key_held, 1);
        run(5);
        check("k3_strobe_one_cycle", kif.code_valid, 0);
        check("k3_single_pulse", pulses, 1);

        // release key 3: key_held drops after the release debounce
        clear_mon();
        kif.key_n = 8'hFF;
        run(6);
        check("k3_held_during_rel_db", kif.key_held, 1);
        run(1);
        check("k3_released", kif.key_held, 0);
        check("k3_keyin_kept", kif.keyin, 3);
        check("k3_rel_no_strobe", pulses, 0);

        // 2-cycle glitch on key 0 is rejected
        clear_mon();
        kif.key_n = 8'hFE;
        run(2);
        kif.key_n = 8'hFF;
        run(12);
        check("glitch_no_strobe", pulses, 0);
        check("glitch_keyin", kif.keyin, 3);
        check("glitch_held", kif.key_held, 0);

        // key 5 bounces for 6 cycles then settles
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            kif.key_n = (i % 2 == 0) ? 8'hDF : 8'hFF;
            run(1);
        end
        kif.key_n = 8'hDF;
        run(14);
        check("bounce_one_strobe", pulses, 1);
        check("bounce_latency", pulse_at(0), 13);
        check("bounce_keyin", kif.keyin, 5);
        check("bounce_held", kif.key_held, 1);
        kif.key_n = 8'hFF;
        run(10);
        check("bounce_released", kif.key_held, 0);

        // keys 5 and 7 together: lowest index wins, dropping key 5 changes nothing
        clear_mon();
        kif.key_n = 8'h5F;
        run(8);
        check("multi_strobe", pulses, 1);
        check("multi_keyin", kif.keyin, 5);
        clear_mon();
        kif.key_n = 8'h7F;
        run(6);
        check("multi_drop_no_strobe", pulses, 0);
        check("multi_drop_keyin", kif.keyin, 5);
        check("multi_drop_held", kif.key_held, 1);
        kif.key_n = 8'hFF;
        run(10);
        check("multi_released", kif.key_held, 0);

        // hold key 6 for 35 cycles after acceptance
        clear_mon();
        kif.key_n = 8'hBF;
        run(42);
        check("hold_first_pulse", pulse_at(0), 7);
`ifdef KEY_AUTO_REPEAT_EN
        check("hold_pulse_count", pulses, 4);
        check("hold_repeat1", pulse_at(1), 17);
        check("hold_repeat2", pulse_at(2), 27);
        check("hold_repeat3", pulse_at(3), 37);
`else
        check("hold_pulse_count", pulses, 1);
`endif
        check("hold_keyin", kif.keyin, 6);
        kif.key_n = 8'hFF;
        run(12);
        check("hold_released", kif.key_held, 0);

        // reset during press debounce discards the pending press
        clear_mon();
        kif.key_n = 8'hFB;
        run(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_keyin", kif.keyin, 0);
        check("mid_rst_held", kif.key_held, 0);
        kif.key_n = 8'hFF;
        run(2);
        rst_n = 1'b1;
        clear_mon();
        run(12);
        check("mid_rst_no_strobe", pulses, 0);
        check("mid_rst_keyin_after", kif.keyin, 0);
        check("mid_rst_held_after", kif.key_held, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
